// File: rtl/prv32_muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// Latency: none, this is wiring only. The master drives start/funct3/a/b/flush; the slave returns busy/done/result.
// Backpressure: start is only honoured while busy is low; there is no stall on the result side.
// Signals: start (request strobe), funct3 (op select), a/b (operands), flush (abort),
//          busy (op in flight), done (one-cycle result pulse), result (held until next done).
interface prv32_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/prv32_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes.
// Latency: XLEN+2 cycles from accept to done; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: start is ignored while busy; flush aborts any operation without a done pulse.
// Ports: clk, rst (sync, active-high), bus (slave modport: start/funct3/a/b/flush in,
//        busy/done/result out).
module prv32_muldiv #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  prv32_muldiv_if.slave      bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t              state_q,  state_d;
  logic [CW-1:0]       cnt_q,    cnt_d;
  logic [2:0]          op_q,     op_d;
  logic                sign_a_q, sign_a_d;
  logic                neg_q,    neg_d;
  logic [XLEN-1:0]     mcand_q,  mcand_d;
  // Multiply: {high, low} product with the multiplier consumed from the low end.
  // Divide: low half holds the dividend shifting out MSB-first while quotient bits shift in at the LSB.
  logic [2*XLEN-1:0]   acc_q,    acc_d;
  logic [XLEN-1:0]     rem_q,    rem_d;
  logic [XLEN-1:0]     result_q, result_d;

  // ---------------------------------------------------------------------------
  // Operand decode for the accept cycle
  // ---------------------------------------------------------------------------
  logic [2:0]      f;
  logic            a_signed, b_signed;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, fast_hit;
  logic [XLEN-1:0] fast_res;

  assign f        = bus.funct3;
  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULHSU keeps rs2 unsigned.
  assign a_signed = (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
  assign b_signed = (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
  assign sign_a   = a_signed & bus.a[XLEN-1];
  assign sign_b   = b_signed & bus.b[XLEN-1];
  assign mag_a    = sign_a ? -bus.a : bus.a;
  assign mag_b    = sign_b ? -bus.b : bus.b;

  assign div_zero = (bus.b == '0);
  assign div_ovf  = ((f == 3'b100) || (f == 3'b110)) && (bus.a == MIN_NEG) && (bus.b == '1);
  assign fast_hit = f[2] && (div_zero || div_ovf);

  // Architectural results for the two divide corner cases; f[1] selects remainder.
  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = f[1] ? bus.a : '1;
    end else begin
      fast_res = f[1] ? '0 : bus.a;
    end
  end

  // ---------------------------------------------------------------------------
  // One radix-2 step of each datapath
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;

  // The carry out of the high-half add becomes the MSB after the right shift.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Partial remainder is XLEN+1 bits wide here; a clear MSB after subtract means no borrow.
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign div_ge    = ~div_diff[XLEN];

  // ---------------------------------------------------------------------------
  // Sign fix-up and final select
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  assign prod_fix = neg_q    ? -acc_q             : acc_q;
  assign quo_fix  = neg_q    ? -acc_q[XLEN-1:0]   : acc_q[XLEN-1:0];
  assign rem_fix  = sign_a_q ? -rem_q             : rem_q;

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath loads
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        // A start in the same cycle as flush is discarded without touching any state.
        if (bus.start && !bus.flush) begin
          op_d     = f;
          sign_a_d = sign_a;
          neg_d    = sign_a ^ sign_b;
          cnt_d    = CW'(XLEN);
          rem_d    = '0;
          if (f[2]) begin
            mcand_d = mag_b;
            acc_d   = {{XLEN{1'b0}}, mag_a};
          end else begin
            mcand_d = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
          end
          if (fast_hit) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q[2]) begin
          rem_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
          acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
        end else begin
          acc_d = mul_next;
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: back to idle with the previous result preserved.
    if (bus.flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule
